// File: rtl/serial_twos_complement_if.sv
// serial_twos_complement_if: operand/result handshake bundle; out_ovf present only with OVF_DETECT_EN.
interface serial_twos_complement_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, in_mode;
  logic [WIDTH-1:0] in_data;
  logic out_valid, out_ready, out_sign, busy;
  logic [WIDTH-1:0] out_data;
`ifdef OVF_DETECT_EN
  logic out_ovf;
`endif
  modport slave (
    input in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sign, busy
`ifdef OVF_DETECT_EN
    , output out_ovf
`endif
  );
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input in_ready, out_valid, out_data, out_sign, busy
`ifdef OVF_DETECT_EN
    , input out_ovf
`endif
  );
endinterface

// File: rtl/serial_twos_complement.sv
// serial_twos_complement: chunked LSB-first negate/abs; OVF_DETECT_EN adds out_ovf for the most negative operand.
module serial_twos_complement #(
  parameter int WIDTH = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst_n,
  serial_twos_complement_if.slave bus
);
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N = WIDTH / BPC;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sreg, res, res_nx;
  logic [CW-1:0] cnt;
  logic sign, invert, carry, last;
  logic [BPC-1:0] x, r;
  logic [BPC:0] sum;
  always_comb begin
    x = sreg[BPC-1:0];
    sum = {1'b0, ~x} + (BPC+1)'(carry);
    r = invert ? sum[BPC-1:0] : x;
    res_nx = (res >> BPC) | (WIDTH'(r) << (WIDTH - BPC));
    last = cnt == CW'(N - 1);
    state_nx = state == IDLE  ? (bus.in_valid ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) :
                                (bus.out_ready ? IDLE : DONE);
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.out_data = res;
  assign bus.out_sign = sign;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sreg <= '0;
      res <= '0;
      cnt <= '0;
      sign <= 1'b0;
      invert <= 1'b0;
      carry <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      sreg <= bus.in_data;
      sign <= bus.in_data[WIDTH-1];
      invert <= !bus.in_mode || bus.in_data[WIDTH-1];
      carry <= !bus.in_mode || bus.in_data[WIDTH-1];
      cnt <= '0;
    end else if (state == SHIFT) begin
      sreg <= sreg >> BPC;
      res <= res_nx;
      carry <= invert & sum[BPC];
      cnt <= cnt + 1'b1;
    end
`ifdef OVF_DETECT_EN
  // The final chunk carries the sign bit, so it is masked out of the zero-run test.
  logic zr, ovf, chunk_zero;
  logic [BPC-1:0] lo_mask;
  always_comb begin
    lo_mask = last ? ~(BPC'(1) << (BPC - 1)) : '1;
    chunk_zero = (x & lo_mask) == '0;
  end
  assign bus.out_ovf = ovf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      zr <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && bus.in_valid) zr <= 1'b1;
    else if (state == SHIFT) begin
      zr <= zr & chunk_zero;
      if (last) ovf <= invert & sign & zr & chunk_zero;
    end
`endif
endmodule

// File: tb/tb_serial_twos_complement.sv
// tb_serial_twos_complement: directed vectors on a bit-serial (BPC=1) and a nibble (BPC=4) instance.
module tb_serial_twos_complement;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;

  serial_twos_complement_if #(.WIDTH(8)) a_if ();
  serial_twos_complement_if #(.WIDTH(8)) b_if ();
  serial_twos_complement #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  serial_twos_complement #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  typedef struct {
    logic mode;
    logic [7:0] din;
    logic [7:0] dout;
    logic sign;
    logic ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ovalid(input int sel);
    return sel != 0 ? b_if.out_valid : a_if.out_valid;
  endfunction
  function automatic logic [7:0] odata(input int sel);
    return sel != 0 ? b_if.out_data : a_if.out_data;
  endfunction
  function automatic logic oovf(input int sel);
`ifdef OVF_DETECT_EN
    return sel != 0 ? b_if.out_ovf : a_if.out_ovf;
`else
    return sel != 0 ? 1'b0 : 1'b0;
`endif
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [7:0] d, input logic m);
    if (sel != 0) begin b_if.in_valid = v; b_if.in_data = d; b_if.in_mode = m; end
    else begin a_if.in_valid = v; a_if.in_data = d; a_if.in_mode = m; end
  endtask
  task automatic drive_ordy(input int sel, input logic v);
    if (sel != 0) b_if.out_ready = v;
    else a_if.out_ready = v;
  endtask

  // Inputs are driven 1 time unit after a rising edge and outputs sampled there too.
  task automatic run_op(input int sel, input logic [7:0] d, input logic m, input int stall,
                        output logic [7:0] r, output logic s, output logic o, output int lat);
    chk("in_ready_idle", sel != 0 ? b_if.in_ready : a_if.in_ready, 1);
    drive_in(sel, 1'b1, d, m);
    @(posedge clk); #1;
    drive_in(sel, 1'b0, ~d, ~m);
    drive_ordy(sel, 1'b1);
    lat = 1;
    while (!ovalid(sel) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = odata(sel);
    s = sel != 0 ? b_if.out_sign : a_if.out_sign;
    o = oovf(sel);
    drive_ordy(sel, 1'b0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", ovalid(sel), 1);
      chk("stall_data", odata(sel), r);
      chk("stall_in_ready", sel != 0 ? b_if.in_ready : a_if.in_ready, 0);
    end
    drive_ordy(sel, 1'b1);
    @(posedge clk); #1;
    drive_ordy(sel, 1'b0);
    chk("valid_cleared", ovalid(sel), 0);
    chk("data_held", odata(sel), r);
  endtask

  initial begin
    vec_t vecs[6];
    logic [7:0] r, exp_r;
    logic s, o, seen;
    int lat;
    vecs[0] = '{1'b0, 8'h05, 8'hFB, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hF6, 8'h0A, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h0A, 8'h0A, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h80, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h7F, 8'h81, 1'b0, 1'b0};
    drive_in(0, 1'b0, 8'h00, 1'b0);
    drive_in(1, 1'b0, 8'h00, 1'b0);
    drive_ordy(0, 1'b0);
    drive_ordy(1, 1'b0);
    repeat (3) @(posedge clk);
    #7 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", a_if.in_ready, 1);
    chk("post_reset_busy", a_if.busy, 0);
    // Asynchronous reset mid-operation, checked before any clock edge.
    drive_in(0, 1'b1, 8'h05, 1'b0);
    drive_in(1, 1'b1, 8'h05, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 8'h00, 1'b0);
    drive_in(1, 1'b0, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", a_if.in_ready, 1);
    chk("async_rst_valid", a_if.out_valid, 0);
    chk("async_rst_data", a_if.out_data, 8'h00);
    chk("async_rst_busy", a_if.busy, 0);
    chk("async_rst_sign_b", b_if.out_sign, 0);
    chk("async_rst_ovf", oovf(0), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    // Vector table on the bit-serial instance; the first one exercises a 3-cycle stall.
    for (int i = 0; i < 6; i++) begin
      run_op(0, vecs[i].din, vecs[i].mode, i == 0 ? 3 : 0, r, s, o, lat);
      chk($sformatf("vec%0d_data", i), r, vecs[i].dout);
      chk($sformatf("vec%0d_sign", i), s, vecs[i].sign);
      chk($sformatf("vec%0d_latency", i), lat, 9);
`ifdef OVF_DETECT_EN
      chk($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
`endif
    end
    // Abort during the fourth SHIFT cycle.
    drive_in(0, 1'b1, 8'h33, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 8'h00, 1'b0);
    drive_ordy(0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", a_if.busy, 0);
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen |= a_if.out_valid; end
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; seen |= a_if.out_valid; end
    chk("abort_no_result", seen, 0);
    drive_ordy(0, 1'b0);
    run_op(0, 8'h33, 1'b0, 0, r, s, o, lat);
    chk("after_abort_data", r, 8'hCD);
    chk("after_abort_latency", lat, 9);
    // Exhaustive sweep on the nibble instance against an arithmetic model.
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < 256; v++) begin
        run_op(1, 8'(v), m[0], $urandom_range(0, 2), r, s, o, lat);
        exp_r = (m == 0 || v >= 128) ? 8'((256 - v) % 256) : 8'(v);
        chk($sformatf("sweep_m%0d_%02h_data", m, v), r, exp_r);
        chk($sformatf("sweep_m%0d_%02h_sign", m, v), s, v >= 128);
        chk($sformatf("sweep_m%0d_%02h_latency", m, v), lat, 3);
`ifdef OVF_DETECT_EN
        chk($sformatf("sweep_m%0d_%02h_ovf", m, v), o, v == 128);
`endif
      end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
